// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_responder_pkg;

   localparam int INST_WORD_W = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DELIVER = 2'd2
   } state_t;

   // Index bits select one buffer entry; the two byte-offset bits are dropped.
   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int entries);
      return INST_WORD_W - 2 - $clog2(entries);
   endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Core fetch port plus backing-memory req/ack port of the fetch responder.
// Latency: n/a (wiring only).
// Backpressure: MEM_WAIT stalls the core; MEM_REQ is held until MEM_ACK.
interface inst_fetch_responder_if;
   import inst_fetch_responder_pkg::*;

   logic                   INVALIDATE;
   logic                   INST_RDEN;
   logic [31:0]            INST_RIADDR;
   logic [31:0]            INST_ROADDR;
   logic                   INST_RVALID;
   logic [INST_WORD_W-1:0] INST_RDATA;
   logic                   MEM_WAIT;
   logic                   MEM_REQ;
   logic [31:0]            MEM_ADDR;
   logic                   MEM_ACK;
   logic [INST_WORD_W-1:0] MEM_RDATA;

   // Environment side: core requests and backing-memory responses.
   modport master (
      output INVALIDATE, INST_RDEN, INST_RIADDR, MEM_ACK, MEM_RDATA,
      input  INST_ROADDR, INST_RVALID, INST_RDATA, MEM_WAIT, MEM_REQ, MEM_ADDR
   );

   // Responder side.
   modport slave (
      input  INVALIDATE, INST_RDEN, INST_RIADDR, MEM_ACK, MEM_RDATA,
      output INST_ROADDR, INST_RVALID, INST_RDATA, MEM_WAIT, MEM_REQ, MEM_ADDR
   );

endinterface

// File: rtl/inst_buf_ram.sv
// Single-port synchronous RAM holding {tag, word} per buffer entry.
// Latency: 1 cycle read (rdata updates on an enabled non-write edge).
// Backpressure: none; ports: clk, en, we, addr, wdata, rdata.
module inst_buf_ram #(
   parameter int ENTRIES = 64,
   parameter int WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [$clog2(ENTRIES)-1:0] addr,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] mem [ENTRIES];

   // rdata holds its last value on write cycles; the fill word is delivered
   // from a separate latch, so no write-through is needed.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/inst_fetch_responder.sv
// Direct-mapped instruction buffer answering core fetches; misses go to backing memory.
// Latency: hit 1 cycle after capture; miss = 1 + fetch cycles + 1 deliver cycle.
// Backpressure: MEM_WAIT stalls capture during a miss; ports: CLK, RST, bus (slave modport).
module inst_fetch_responder
   import inst_fetch_responder_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input logic                   CLK,
   input logic                   RST,
   inst_fetch_responder_if.slave bus
);

   localparam int IDX   = idx_w(ENTRIES);
   localparam int TAG   = tag_w(ENTRIES);
   localparam int RAM_W = TAG + INST_WORD_W;

   state_t                 state_q, state_d;
   logic                   req_v;
   logic [29:0]            req_word;   // captured address bits [31:2]
   logic [ENTRIES-1:0]     valid_q;
   logic                   inv_pend;
   logic [INST_WORD_W-1:0] fill_data;
   logic [RAM_W-1:0]       ram_rdata;
   logic [IDX-1:0]         req_idx;
   logic [TAG-1:0]         req_tag;
   logic                   hit;
   logic                   capture;
   logic                   fill;
   logic                   mem_wait;
   logic                   mem_req;
   logic                   rsp_vld;
   logic [INST_WORD_W-1:0] rsp_data;

   assign req_idx = req_word[IDX-1:0];
   assign req_tag = req_word[29:IDX];
   assign hit     = valid_q[req_idx] && (ram_rdata[RAM_W-1:INST_WORD_W] == req_tag);
   assign capture = bus.INST_RDEN && !mem_wait;
   assign fill    = (state_q == S_FETCH) && bus.MEM_ACK;

   // The single RAM port reads at capture and writes on the fill edge; the
   // two never coincide because capture is blocked while fetching.
   inst_buf_ram #(
      .ENTRIES (ENTRIES),
      .WIDTH   (RAM_W)
   ) u_ram (
      .clk   (CLK),
      .en    (capture || fill),
      .we    (fill),
      .addr  (fill ? req_idx : bus.INST_RIADDR[IDX+1:2]),
      .wdata ({req_tag, bus.MEM_RDATA}),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mem_wait = 1'b0;
      mem_req  = 1'b0;
      rsp_vld  = 1'b0;
      rsp_data = ram_rdata[INST_WORD_W-1:0];
      case (state_q)
         S_IDLE: begin
            if (req_v) begin
               if (hit) begin
                  rsp_vld = 1'b1;
               end else begin
                  mem_wait = 1'b1;   // stall already in the lookup cycle
                  state_d  = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            mem_wait = 1'b1;
            mem_req  = 1'b1;
            if (bus.MEM_ACK) begin
               state_d = S_DELIVER;
            end
         end
         S_DELIVER: begin
            rsp_vld  = 1'b1;
            rsp_data = fill_data;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // req_v follows the strobe whenever the core is not stalled, so a cycle
   // without INST_RDEN yields no response; during a stall it holds.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_v    <= 1'b0;
         req_word <= '0;
      end else if (!mem_wait) begin
         req_v <= bus.INST_RDEN;
         if (bus.INST_RDEN) begin
            req_word <= bus.INST_RIADDR[31:2];
         end
      end
   end

   // Remembers an invalidate seen earlier in this fetch so the fill, though
   // still delivered, is not marked valid.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         inv_pend <= 1'b0;
      end else if ((state_q == S_FETCH) && !bus.MEM_ACK) begin
         inv_pend <= inv_pend || bus.INVALIDATE;
      end else begin
         inv_pend <= 1'b0;
      end
   end

   // Invalidate takes priority over setting the filled entry valid.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= '0;
      end else if (bus.INVALIDATE) begin
         valid_q <= '0;
      end else if (fill && !inv_pend) begin
         valid_q[req_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fill_data <= '0;
      end else if (fill) begin
         fill_data <= bus.MEM_RDATA;
      end
   end

   // Address/data outputs are gated so they read zero when not meaningful.
   assign bus.MEM_WAIT    = mem_wait;
   assign bus.MEM_REQ     = mem_req;
   assign bus.MEM_ADDR    = mem_req ? {req_word, 2'b00} : 32'd0;
   assign bus.INST_RVALID = rsp_vld;
   assign bus.INST_RDATA  = rsp_vld ? rsp_data : '0;
   assign bus.INST_ROADDR = rsp_vld ? {req_word, 2'b00} : 32'd0;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder against a direct-mapped buffer model.
// Latency: checks hit, miss and deliver timing cycle by cycle.
// Backpressure: emulates backing memory with configurable ack delay.
module tb_inst_fetch_responder;
   localparam int ENTRIES = 64;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   // Model: per entry, whether it holds a word, which aligned address, and the data.
   bit          ref_valid [ENTRIES];
   logic [31:0] ref_addr  [ENTRIES];
   logic [31:0] ref_data  [ENTRIES];

   inst_fetch_responder_if bus ();

   inst_fetch_responder #(.ENTRIES(ENTRIES)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic void model_clear();
      for (int i = 0; i < ENTRIES; i++) ref_valid[i] = 1'b0;
   endfunction

   // One request; returns whether the DUT answered as a hit in the next cycle.
   task automatic fetch(input logic [31:0] addr, input int ack_dly, input int inv_at,
                        input logic [31:0] fill, output bit hit_obs);
      logic [31:0] al;
      int          idx;
      bit          exp_hit;
      bit          inv;
      int          waits;
      al      = addr & 32'hFFFF_FFFC;
      idx     = int'((al / 4) % ENTRIES);
      exp_hit = ref_valid[idx] && (ref_addr[idx] == al);
      inv     = 1'b0;
      waits   = 0;
      bus.INST_RDEN   = 1'b1;
      bus.INST_RIADDR = addr;
      @(posedge CLK); @(negedge CLK);
      hit_obs = bus.INST_RVALID;
      checks++; if (bus.INST_RVALID !== exp_hit) begin failures++; $display("FAIL lookup_rvalid addr=%h got=%b exp=%b", addr, bus.INST_RVALID, exp_hit); end
      if (exp_hit) begin
         checks++; if (bus.INST_RDATA !== ref_data[idx]) begin failures++; $display("FAIL hit_data addr=%h got=%h exp=%h", addr, bus.INST_RDATA, ref_data[idx]); end
         checks++; if (bus.INST_ROADDR !== al) begin failures++; $display("FAIL hit_roaddr addr=%h got=%h exp=%h", addr, bus.INST_ROADDR, al); end
         checks++; if (bus.MEM_WAIT !== 1'b0) begin failures++; $display("FAIL hit_wait addr=%h got=%b exp=0", addr, bus.MEM_WAIT); end
         bus.INST_RDEN = 1'b0;
         return;
      end
      checks++; if (bus.MEM_REQ !== 1'b0) begin failures++; $display("FAIL miss_req_early addr=%h got=%b exp=0", addr, bus.MEM_REQ); end
      if (bus.MEM_WAIT === 1'b1) waits++;
      // The core keeps RDEN/address asserted while stalled; the DUT must ignore it.
      for (int c = 0; c <= ack_dly; c++) begin
         @(posedge CLK); @(negedge CLK);
         bus.INVALIDATE = 1'b0;
         checks++; if (bus.MEM_REQ !== 1'b1) begin failures++; $display("FAIL fetch_req addr=%h cyc=%0d got=%b exp=1", addr, c, bus.MEM_REQ); end
         checks++; if (bus.MEM_ADDR !== al) begin failures++; $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", c, bus.MEM_ADDR, al); end
         checks++; if (bus.INST_RVALID !== 1'b0) begin failures++; $display("FAIL fetch_rvalid cyc=%0d got=%b exp=0", c, bus.INST_RVALID); end
         if (bus.MEM_WAIT === 1'b1) waits++;
         if (c == inv_at) begin bus.INVALIDATE = 1'b1; inv = 1'b1; end
         if (c == ack_dly) begin bus.MEM_ACK = 1'b1; bus.MEM_RDATA = fill; end
      end
      @(posedge CLK); @(negedge CLK);
      bus.MEM_ACK    = 1'b0;
      bus.MEM_RDATA  = $urandom;
      bus.INVALIDATE = 1'b0;
      checks++; if (bus.INST_RVALID !== 1'b1) begin failures++; $display("FAIL deliver_rvalid addr=%h got=%b exp=1", addr, bus.INST_RVALID); end
      checks++; if (bus.INST_RDATA !== fill) begin failures++; $display("FAIL deliver_data addr=%h got=%h exp=%h", addr, bus.INST_RDATA, fill); end
      checks++; if (bus.INST_ROADDR !== al) begin failures++; $display("FAIL deliver_roaddr got=%h exp=%h", bus.INST_ROADDR, al); end
      checks++; if (bus.MEM_WAIT !== 1'b0 || bus.MEM_REQ !== 1'b0) begin failures++; $display("FAIL deliver_wait_req got=%b%b exp=00", bus.MEM_WAIT, bus.MEM_REQ); end
      checks++; if (waits !== ack_dly + 2) begin failures++; $display("FAIL wait_cycles addr=%h got=%0d exp=%0d", addr, waits, ack_dly + 2); end
      if (inv) begin
         model_clear();
      end else begin
         ref_valid[idx] = 1'b1;
         ref_addr[idx]  = al;
         ref_data[idx]  = fill;
      end
      bus.INST_RDEN = 1'b0;
   endtask

   task automatic idle_cycle(input bit inv);
      bus.INST_RDEN  = 1'b0;
      bus.INVALIDATE = inv;
      @(posedge CLK); @(negedge CLK);
      bus.INVALIDATE = 1'b0;
      if (inv) model_clear();
      checks++; if (bus.INST_RVALID !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b exp=0", bus.INST_RVALID); end
      checks++; if (bus.MEM_WAIT !== 1'b0) begin failures++; $display("FAIL idle_wait got=%b exp=0", bus.MEM_WAIT); end
   endtask

   task automatic test_reset();
      @(negedge CLK); @(negedge CLK);
      checks++; if ({bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID}); end
      checks++; if ({bus.INST_RDATA, bus.INST_ROADDR, bus.MEM_ADDR} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.INST_RDATA, bus.INST_ROADDR, bus.MEM_ADDR}); end
      RST = 1'b0;
      model_clear();
      idle_cycle(1'b0);
   endtask

   task automatic test_cold_miss();
      bit h;
      fetch(32'h0000_0100, 3, -1, 32'h0000_0013, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL cold_miss_hit got=%b exp=0", h); end
   endtask

   task automatic test_hit_stream();
      logic [31:0] a [4];
      bit h;
      for (int i = 0; i < 4; i++) a[i] = 32'h100 + 32'(4 * i);
      for (int i = 1; i < 4; i++) fetch(a[i], i - 1, -1, $urandom, h);
      bus.INST_RDEN   = 1'b1;
      bus.INST_RIADDR = a[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); @(negedge CLK);
         checks++; if (bus.INST_RVALID !== 1'b1 || bus.MEM_WAIT !== 1'b0) begin failures++; $display("FAIL stream_vld_wait i=%0d got=%b%b exp=10", i, bus.INST_RVALID, bus.MEM_WAIT); end
         checks++; if (bus.INST_RDATA !== ref_data[(a[i] / 4) % ENTRIES]) begin failures++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, bus.INST_RDATA, ref_data[(a[i] / 4) % ENTRIES]); end
         checks++; if (bus.INST_ROADDR !== a[i]) begin failures++; $display("FAIL stream_roaddr i=%0d got=%h exp=%h", i, bus.INST_ROADDR, a[i]); end
         if (i < 3) bus.INST_RIADDR = a[i + 1];
         else bus.INST_RDEN = 1'b0;
      end
      idle_cycle(1'b0);
   endtask

   task automatic test_conflict();
      bit h;
      fetch(32'h0000_0200, 1, -1, $urandom, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL conflict_miss_200 got=%b exp=0", h); end
      fetch(32'h0000_0100, 0, -1, 32'h0000_0013, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL conflict_remiss_100 got=%b exp=0", h); end
   endtask

   task automatic test_misaligned_rden();
      bit h;
      idle_cycle(1'b0);
      idle_cycle(1'b0);
      fetch(32'h0000_0103, 0, -1, 32'h0, h);
      checks++; if (h !== 1'b1) begin failures++; $display("FAIL misaligned_hit got=%b exp=1", h); end
      idle_cycle(1'b0);
   endtask

   task automatic test_inval_fetch();
      bit h;
      fetch(32'h0000_0040, 2, 1, 32'hDEAD_BEEF, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL inval_first_miss got=%b exp=0", h); end
      idle_cycle(1'b0);
      fetch(32'h0000_0040, 1, -1, 32'hDEAD_BEEF, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL inval_remiss got=%b exp=0", h); end
      // Invalidate coinciding with the ack cycle must also suppress the install.
      fetch(32'h0000_0044, 0, 0, 32'h1111_2222, h);
      fetch(32'h0000_0044, 0, -1, 32'h1111_2222, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL inval_ack_remiss got=%b exp=0", h); end
   endtask

   task automatic test_reset_mid_fetch();
      bit h;
      bus.INST_RDEN   = 1'b1;
      bus.INST_RIADDR = 32'h0000_07F0;
      @(posedge CLK); @(negedge CLK);
      @(posedge CLK); @(negedge CLK);
      checks++; if (bus.MEM_REQ !== 1'b1) begin failures++; $display("FAIL rstmid_pre_req got=%b exp=1", bus.MEM_REQ); end
      #2;
      RST = 1'b1;
      bus.INST_RDEN = 1'b0;
      #1;
      checks++; if ({bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID} !== 3'b000) begin failures++; $display("FAIL rstmid_async got=%b exp=000", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID}); end
      checks++; if (bus.MEM_ADDR !== 32'd0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", bus.MEM_ADDR); end
      @(negedge CLK);
      RST = 1'b0;
      model_clear();
      bus.MEM_ACK   = 1'b1;
      bus.MEM_RDATA = 32'h0BAD_0BAD;
      @(posedge CLK); @(negedge CLK);
      bus.MEM_ACK = 1'b0;
      checks++; if ({bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID} !== 3'b000) begin failures++; $display("FAIL late_ack got=%b exp=000", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID}); end
      idle_cycle(1'b0);
      fetch(32'h0000_07F0, 1, -1, 32'h1234_5678, h);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL rstmid_refetch_miss got=%b exp=0", h); end
   endtask

   task automatic test_random();
      bit          h;
      logic [31:0] a;
      int          d;
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            idle_cycle($urandom_range(0, 2) == 0);
         end else begin
            a = 32'($urandom_range(0, 1) * 256 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            d = $urandom_range(0, 3);
            fetch(a, d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, d)) : -1, $urandom, h);
         end
      end
   endtask

   initial begin
      bus.INVALIDATE  = 1'b0;
      bus.INST_RDEN   = 1'b0;
      bus.INST_RIADDR = 32'd0;
      bus.MEM_ACK     = 1'b0;
      bus.MEM_RDATA   = 32'd0;
      test_reset();
      test_cold_miss();
      test_hit_stream();
      test_conflict();
      test_misaligned_rden();
      test_inval_fetch();
      test_reset_mid_fetch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
